level_alarm_ctrl: RTL and testbench
===================================

Name: level_alarm_ctrl

Overview:
Processing stage between the sensor/button front end and the 7-segment display driver in the liquid level meter. Filters the raw 8-probe thermometer code and converts it to a 0–8 level. Stores the user-set high and low thresholds on debounced save pulses. Runs a hysteresis alarm state machine that drives LED1 (high alarm) and LED2 (low alarm); level and thresholds are exported for display.

Parameters:
STABLE_CYCLES, 1_000_000, consecutive cycles a synchronised sensor code must hold before acceptance (10 ms at 100 MHz)
BLINK_CYCLES, 25_000_000, LED half-period in alarm states (250 ms)
HYST, 1, hysteresis in level steps for alarm exit
THR_H_RST, 7, high threshold after reset
THR_L_RST, 1, low threshold after reset

Ports:
clk_100MHz  in  1  system clock
reset_n  in  1  synchronous, active-low reset
sensors_input  in  8  raw probe bits, asynchronous, bit0 = lowest probe
setup_input  in  8  threshold switches, thermometer code
saveH_pulse  in  1  one-cycle debounced save-high request
saveL_pulse  in  1  one-cycle debounced save-low request
level  out  4  accepted level 1..8, 0 when fault
level_valid  out  1  accepted code is a legal thermometer code
thr_high  out  4  stored high threshold
thr_low  out  4  stored low threshold
save_reject  out  1  one-cycle pulse: save request refused
LED1  out  1  high-alarm LED
LED2  out  1  low-alarm LED

Behaviour:
- Reset (reset_n=0 at clk edge): level=0, level_valid=0, thr_high=THR_H_RST, thr_low=THR_L_RST, save_reject=0, LED1=LED2=0, state=FAULT, sync/stable/blink counters cleared. Reset mid-debounce or mid-blink discards progress.
- Sensor path: 2-flop synchroniser, then stability counter. The counter resets whenever the synchronised code differs from the previous cycle. The code is accepted when it has been unchanged for STABLE_CYCLES cycles. Latency from an input change to a level update is STABLE_CYCLES+2 cycles. An input toggling faster than that never updates level.
- Legal code: 0…01…1 with at least one bit set (00000001..11111111). level = popcount, level_valid=1.
- Illegal code (non-contiguous, or 00000000 meaning a dry or disconnected harness): level=0, level_valid=0.
- Threshold save (same cycle as the pulse; registers update on the next edge):
  - saveH_pulse alone: accepted if setup_input is legal and its popcount > thr_low; otherwise thr_high is unchanged and save_reject=1 for one cycle.
  - saveL_pulse alone: accepted if setup_input is legal and its popcount < thr_high; otherwise rejected as above.
  - Both pulses in the same cycle: both are ignored and save_reject=1.
- FSM (evaluated every cycle from registered level, level_valid, thresholds):
  - FAULT: entered from any state when level_valid=0. When level_valid=1, exits to HIGH if level>=thr_high, LOW if level<=thr_low, otherwise NORMAL.
  - NORMAL: to HIGH if level>=thr_high; to LOW if level<=thr_low.
  - HIGH: to NORMAL when level+HYST < thr_high.
  - LOW: to NORMAL when level > thr_low+HYST.
  - A threshold change takes effect on the cycle after it is stored, and may itself move the state.
- LEDs (registered, 1 cycle after state):
  - NORMAL: 0/0.
  - HIGH: LED1 blinks at BLINK_CYCLES half-period starting ON, LED2=0.
  - LOW: LED2 blinks starting ON, LED1=0.
  - FAULT: both solid ON.
  - The blink counter restarts on every state entry.
- Width rules: level+HYST is computed at 5 bits, with no wrap.

Test Plan:
- Reset held 10 cycles, then sensors=00001111 (sim STABLE_CYCLES=16, BLINK_CYCLES=8) -> level=0/FAULT, LED1=LED2=1 until cycle 18 after the change, then level=4, level_valid=1, LEDs 0/0.
- sensors=00111111, setup=01111111, saveH -> thr_high=7, state NORMAL; sensors=01111111 -> HIGH, LED1 toggles every 8 cycles starting ON; sensors=00111111 -> remains HIGH (6+1 not <7); 00011111 -> NORMAL.
- setup=00000001, saveL with thr_low=1 -> thr_low=1 stored; sensors=00000001 -> LOW, LED2 blinks; sensors=00000111 -> NORMAL (3>2).
- setup=00110011 with saveH -> save_reject pulses, thr_high unchanged; setup=00000001 with saveH while thr_low=1 -> rejected; saveH and saveL in the same cycle -> rejected, both thresholds unchanged.
- sensors=00110011, then 00000000 -> after the filter, level=0, level_valid=0, FAULT, both LEDs solid.
- sensors alternate 00001111/00011111 every 10 cycles -> level never updates; reset_n low mid-alarm -> all outputs return to reset values on the next edge.

Source files
------------

// File: rtl/level_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// level_alarm_ctrl
//
// Sits between the probe/button front end and the 7-segment driver of the
// liquid level meter. It debounces the raw 8-probe thermometer code into a
// 0..8 level, keeps the user-set high/low thresholds, and runs the
// hysteresis alarm state machine that drives the two alarm LEDs.
//
// Ports
//   clk_100MHz     in   1  system clock
//   reset_n        in   1  synchronous active-low reset
//   sensors_input  in   8  raw probe bits (asynchronous), bit0 = lowest probe
//   setup_input    in   8  threshold switches, thermometer code
//   saveH_pulse    in   1  one-cycle request to store setup_input as high thr
//   saveL_pulse    in   1  one-cycle request to store setup_input as low thr
//   level          out  4  accepted level 1..8, 0 on fault
//   level_valid    out  1  accepted code is a legal thermometer code
//   thr_high       out  4  stored high threshold
//   thr_low        out  4  stored low threshold
//   save_reject    out  1  one-cycle pulse, a save request was refused
//   LED1           out  1  high-alarm LED
//   LED2           out  1  low-alarm LED
//
// Alarm states
//   state     | meaning
//   ----------+--------------------------------------------------------
//   ST_FAULT  | accepted code illegal or dry harness, both LEDs solid on
//   ST_NORMAL | level strictly between the thresholds, LEDs off
//   ST_HIGH   | level at/above high threshold, LED1 blinks
//   ST_LOW    | level at/below low threshold, LED2 blinks
// -----------------------------------------------------------------------------
module level_alarm_ctrl #(
    parameter int STABLE_CYCLES = 1_000_000,
    parameter int BLINK_CYCLES  = 25_000_000,
    parameter int HYST          = 1,
    parameter int THR_H_RST     = 7,
    parameter int THR_L_RST     = 1
) (
    input  logic       clk_100MHz,
    input  logic       reset_n,
    input  logic [7:0] sensors_input,
    input  logic [7:0] setup_input,
    input  logic       saveH_pulse,
    input  logic       saveL_pulse,
    output logic [3:0] level,
    output logic       level_valid,
    output logic [3:0] thr_high,
    output logic [3:0] thr_low,
    output logic       save_reject,
    output logic       LED1,
    output logic       LED2
);

    localparam int STAB_W  = $clog2(STABLE_CYCLES + 1);
    localparam int BLINK_W = $clog2(BLINK_CYCLES + 1);

    localparam logic [STAB_W-1:0]  STAB_RELOAD  = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [BLINK_W-1:0] BLINK_RELOAD = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [STAB_W-1:0]  STAB_ONE     = STAB_W'(1);
    localparam logic [BLINK_W-1:0] BLINK_ONE    = BLINK_W'(1);

    typedef enum logic [1:0] {
        ST_FAULT  = 2'd0,
        ST_NORMAL = 2'd1,
        ST_HIGH   = 2'd2,
        ST_LOW    = 2'd3
    } state_t;

    // 0..01..1 with at least one bit set; x & (x+1) clears the low run of ones
    function automatic logic is_thermo(input logic [7:0] code);
        return (code != 8'd0) && ((code & (code + 8'd1)) == 8'd0);
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] code);
        logic [3:0] cnt;
        cnt = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt = cnt + {3'd0, code[i]};
        end
        return cnt;
    endfunction

    // ------------------------------------------------------------------
    // Sensor path: synchroniser + stability down-counter
    // ------------------------------------------------------------------
    logic [7:0]        r_sync1;
    logic [7:0]        r_sync2;
    logic [STAB_W-1:0] r_stab_cnt;
    logic [3:0]        r_level;
    logic              r_level_valid;

    logic              w_code_same;
    logic              w_accept;
    logic              w_code_legal;
    logic [3:0]        w_code_lvl;

    // r_sync1 is the value r_sync2 takes on the next edge, so comparing the
    // two flags a change one cycle early and the counter reloads on the
    // same edge the new code lands in r_sync2.
    assign w_code_same  = (r_sync1 == r_sync2);
    assign w_accept     = w_code_same && (r_stab_cnt == '0);
    assign w_code_legal = is_thermo(r_sync2);
    assign w_code_lvl   = popcount8(r_sync2);

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_sync1       <= 8'd0;
            r_sync2       <= 8'd0;
            r_stab_cnt    <= '0;
            r_level       <= 4'd0;
            r_level_valid <= 1'b0;
        end else begin
            r_sync1 <= sensors_input;
            r_sync2 <= r_sync1;

            if (!w_code_same) begin
                r_stab_cnt <= STAB_RELOAD;
            end else if (r_stab_cnt != '0) begin
                r_stab_cnt <= r_stab_cnt - STAB_ONE;
            end

            // Re-accepting the same code every cycle once settled is harmless.
            if (w_accept) begin
                if (w_code_legal) begin
                    r_level       <= w_code_lvl;
                    r_level_valid <= 1'b1;
                end else begin
                    r_level       <= 4'd0;
                    r_level_valid <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Threshold storage
    // ------------------------------------------------------------------
    logic [3:0] r_thr_high;
    logic [3:0] r_thr_low;
    logic       r_save_reject;

    logic       w_setup_legal;
    logic [3:0] w_setup_lvl;
    logic [3:0] w_thr_high_nxt;
    logic [3:0] w_thr_low_nxt;
    logic       w_reject;

    assign w_setup_legal = is_thermo(setup_input);
    assign w_setup_lvl   = popcount8(setup_input);

    // Thresholds must stay strictly ordered (low < high); simultaneous
    // requests are ambiguous and are refused as a whole.
    always_comb begin
        w_thr_high_nxt = r_thr_high;
        w_thr_low_nxt  = r_thr_low;
        w_reject       = 1'b0;
        if (saveH_pulse && saveL_pulse) begin
            w_reject = 1'b1;
        end else if (saveH_pulse) begin
            if (w_setup_legal && (w_setup_lvl > r_thr_low)) begin
                w_thr_high_nxt = w_setup_lvl;
            end else begin
                w_reject = 1'b1;
            end
        end else if (saveL_pulse) begin
            if (w_setup_legal && (w_setup_lvl < r_thr_high)) begin
                w_thr_low_nxt = w_setup_lvl;
            end else begin
                w_reject = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_thr_high    <= 4'(THR_H_RST);
            r_thr_low     <= 4'(THR_L_RST);
            r_save_reject <= 1'b0;
        end else begin
            r_thr_high    <= w_thr_high_nxt;
            r_thr_low     <= w_thr_low_nxt;
            r_save_reject <= w_reject;
        end
    end

    // ------------------------------------------------------------------
    // Alarm FSM
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;
    logic [BLINK_W-1:0] r_blink_cnt;
    logic               r_blink_on;
    logic               r_led1;
    logic               r_led2;

    logic               w_led1_nxt;
    logic               w_led2_nxt;
    logic               w_state_entry;
    logic               w_at_high;
    logic               w_at_low;
    logic [4:0]         w_level_hyst;
    logic [4:0]         w_thr_low_hyst;

    // Extra bit keeps level+HYST and thr_low+HYST from wrapping.
    assign w_level_hyst   = {1'b0, r_level} + 5'(HYST);
    assign w_thr_low_hyst = {1'b0, r_thr_low} + 5'(HYST);
    assign w_at_high      = (r_level >= r_thr_high);
    assign w_at_low       = (r_level <= r_thr_low);
    assign w_state_entry  = (w_state_nxt != r_state);

    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_state <= ST_FAULT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_led1_nxt  = 1'b0;
        w_led2_nxt  = 1'b0;

        if (!r_level_valid) begin
            w_state_nxt = ST_FAULT;
        end else begin
            case (r_state)
                ST_FAULT: begin
                    if (w_at_high) begin
                        w_state_nxt = ST_HIGH;
                    end else if (w_at_low) begin
                        w_state_nxt = ST_LOW;
                    end else begin
                        w_state_nxt = ST_NORMAL;
                    end
                end
                ST_NORMAL: begin
                    if (w_at_high) begin
                        w_state_nxt = ST_HIGH;
                    end else if (w_at_low) begin
                        w_state_nxt = ST_LOW;
                    end
                end
                ST_HIGH: begin
                    if (w_level_hyst < {1'b0, r_thr_high}) begin
                        w_state_nxt = ST_NORMAL;
                    end
                end
                ST_LOW: begin
                    if ({1'b0, r_level} > w_thr_low_hyst) begin
                        w_state_nxt = ST_NORMAL;
                    end
                end
                default: w_state_nxt = ST_FAULT;
            endcase
        end

        case (r_state)
            ST_FAULT: begin
                w_led1_nxt = 1'b1;
                w_led2_nxt = 1'b1;
            end
            ST_HIGH:  w_led1_nxt = r_blink_on;
            ST_LOW:   w_led2_nxt = r_blink_on;
            default: begin
                w_led1_nxt = 1'b0;
                w_led2_nxt = 1'b0;
            end
        endcase
    end

    // Blink phase restarts ON at every state entry, so an alarm always
    // shows a full ON half-period first.
    always_ff @(posedge clk_100MHz) begin
        if (!reset_n) begin
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
            r_led1      <= 1'b0;
            r_led2      <= 1'b0;
        end else begin
            if (w_state_entry) begin
                r_blink_cnt <= BLINK_RELOAD;
                r_blink_on  <= 1'b1;
            end else if (r_blink_cnt == '0) begin
                r_blink_cnt <= BLINK_RELOAD;
                r_blink_on  <= ~r_blink_on;
            end else begin
                r_blink_cnt <= r_blink_cnt - BLINK_ONE;
            end
            r_led1 <= w_led1_nxt;
            r_led2 <= w_led2_nxt;
        end
    end

    assign level       = r_level;
    assign level_valid = r_level_valid;
    assign thr_high    = r_thr_high;
    assign thr_low     = r_thr_low;
    assign save_reject = r_save_reject;
    assign LED1        = r_led1;
    assign LED2        = r_led2;

endmodule

// File: tb/tb_level_alarm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_level_alarm_ctrl
//
// Directed bench for level_alarm_ctrl with STABLE_CYCLES=16, BLINK_CYCLES=8.
// Inputs change 1 ns after a rising edge; a code change is captured by the
// first synchroniser flop on the next edge, the level updates 18 edges after
// the change, the FSM one edge later and the LEDs one edge after that.
// -----------------------------------------------------------------------------
module tb_level_alarm_ctrl;

    logic       clk_100MHz;
    logic       reset_n;
    logic [7:0] sensors_input;
    logic [7:0] setup_input;
    logic       saveH_pulse;
    logic       saveL_pulse;
    logic [3:0] level;
    logic       level_valid;
    logic [3:0] thr_high;
    logic [3:0] thr_low;
    logic       save_reject;
    logic       LED1;
    logic       LED2;

    int n_vec = 0;
    int n_err = 0;

    level_alarm_ctrl #(
        .STABLE_CYCLES(16),
        .BLINK_CYCLES (8),
        .HYST         (1),
        .THR_H_RST    (7),
        .THR_L_RST    (1)
    ) dut (
        .clk_100MHz   (clk_100MHz),
        .reset_n      (reset_n),
        .sensors_input(sensors_input),
        .setup_input  (setup_input),
        .saveH_pulse  (saveH_pulse),
        .saveL_pulse  (saveL_pulse),
        .level        (level),
        .level_valid  (level_valid),
        .thr_high     (thr_high),
        .thr_low      (thr_low),
        .save_reject  (save_reject),
        .LED1         (LED1),
        .LED2         (LED2)
    );

    initial clk_100MHz = 1'b0;
    always #5 clk_100MHz = ~clk_100MHz;

    typedef struct {
        logic [7:0] sensors;
        logic [7:0] setup;
        logic       save_h;
        logic       save_l;
        int         wait_cyc;
        logic [3:0] level;
        logic       valid;
        logic [3:0] thr_h;
        logic [3:0] thr_l;
        logic       led1;
        logic       led2;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk_100MHz);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] e_lvl, input logic e_vld,
                           input logic [3:0] e_th, input logic [3:0] e_tl,
                           input logic e_l1, input logic e_l2);
        chk({tag, " level"},       8'(level),       8'(e_lvl));
        chk({tag, " level_valid"}, 8'(level_valid), 8'(e_vld));
        chk({tag, " thr_high"},    8'(thr_high),    8'(e_th));
        chk({tag, " thr_low"},     8'(thr_low),     8'(e_tl));
        chk({tag, " LED1"},        8'(LED1),        8'(e_l1));
        chk({tag, " LED2"},        8'(LED2),        8'(e_l2));
    endtask

    task automatic save(input logic [7:0] setup, input logic h, input logic l);
        setup_input = setup;
        saveH_pulse = h;
        saveL_pulse = l;
        tick(1);
        saveH_pulse = 1'b0;
        saveL_pulse = 1'b0;
    endtask

    initial begin
        //          sens   setup  H     L     wait lvl   vld   thH   thL   L1    L2
        vecs[0]  = '{8'h3F, 8'h7F, 1'b1, 1'b0, 20, 4'd6, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[1]  = '{8'h7F, 8'h7F, 1'b0, 1'b0, 20, 4'd7, 1'b1, 4'd7, 4'd1, 1'b1, 1'b0};
        vecs[2]  = '{8'h7F, 8'h7F, 1'b0, 1'b0,  7, 4'd7, 1'b1, 4'd7, 4'd1, 1'b1, 1'b0};
        vecs[3]  = '{8'h7F, 8'h7F, 1'b0, 1'b0,  1, 4'd7, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[4]  = '{8'h7F, 8'h7F, 1'b0, 1'b0,  8, 4'd7, 1'b1, 4'd7, 4'd1, 1'b1, 1'b0};
        vecs[5]  = '{8'h3F, 8'h7F, 1'b0, 1'b0, 20, 4'd6, 1'b1, 4'd7, 4'd1, 1'b1, 1'b0};
        vecs[6]  = '{8'h1F, 8'h7F, 1'b0, 1'b0, 20, 4'd5, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[7]  = '{8'h1F, 8'h01, 1'b0, 1'b1, 20, 4'd5, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[8]  = '{8'h01, 8'h01, 1'b0, 1'b0, 20, 4'd1, 1'b1, 4'd7, 4'd1, 1'b0, 1'b1};
        vecs[9]  = '{8'h01, 8'h01, 1'b0, 1'b0,  8, 4'd1, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[10] = '{8'h07, 8'h01, 1'b0, 1'b0, 20, 4'd3, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[11] = '{8'h07, 8'h33, 1'b1, 1'b0,  3, 4'd3, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[12] = '{8'h07, 8'h01, 1'b1, 1'b0,  3, 4'd3, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[13] = '{8'h07, 8'h0F, 1'b1, 1'b1,  3, 4'd3, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[14] = '{8'h07, 8'h1F, 1'b1, 1'b0,  3, 4'd3, 1'b1, 4'd5, 4'd1, 1'b0, 1'b0};
        vecs[15] = '{8'h07, 8'h07, 1'b0, 1'b1,  3, 4'd3, 1'b1, 4'd5, 4'd3, 1'b0, 1'b1};
        vecs[16] = '{8'h07, 8'h3F, 1'b0, 1'b1,  3, 4'd3, 1'b1, 4'd5, 4'd3, 1'b0, 1'b1};
        vecs[17] = '{8'h07, 8'h0F, 1'b0, 1'b1,  3, 4'd3, 1'b1, 4'd5, 4'd4, 1'b0, 1'b1};
        vecs[18] = '{8'h07, 8'h01, 1'b0, 1'b1,  3, 4'd3, 1'b1, 4'd5, 4'd1, 1'b0, 1'b0};
        vecs[19] = '{8'h07, 8'h7F, 1'b1, 1'b0,  3, 4'd3, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};
        vecs[20] = '{8'h33, 8'h7F, 1'b0, 1'b0, 20, 4'd0, 1'b0, 4'd7, 4'd1, 1'b1, 1'b1};
        vecs[21] = '{8'h00, 8'h7F, 1'b0, 1'b0, 20, 4'd0, 1'b0, 4'd7, 4'd1, 1'b1, 1'b1};
        vecs[22] = '{8'hFF, 8'h7F, 1'b0, 1'b0, 20, 4'd8, 1'b1, 4'd7, 4'd1, 1'b1, 1'b0};
        vecs[23] = '{8'h0F, 8'h7F, 1'b0, 1'b0, 20, 4'd4, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0};

        reset_n       = 1'b0;
        sensors_input = 8'h00;
        setup_input   = 8'h00;
        saveH_pulse   = 1'b0;
        saveL_pulse   = 1'b0;

        // Reset and first acceptance
        tick(10);
        chk_all("reset", 4'd0, 1'b0, 4'd7, 4'd1, 1'b0, 1'b0);
        chk("reset save_reject", 8'(save_reject), 8'h0);
        reset_n       = 1'b1;
        sensors_input = 8'h0F;
        tick(1);
        chk_all("post-reset fault", 4'd0, 1'b0, 4'd7, 4'd1, 1'b1, 1'b1);
        tick(16);
        chk_all("filter c17", 4'd0, 1'b0, 4'd7, 4'd1, 1'b1, 1'b1);
        tick(1);
        chk_all("filter c18", 4'd4, 1'b1, 4'd7, 4'd1, 1'b1, 1'b1);
        tick(2);
        chk_all("normal c20", 4'd4, 1'b1, 4'd7, 4'd1, 1'b0, 1'b0);

        // Vector table: each entry changes inputs, waits, then compares
        for (int i = 0; i < NVEC; i++) begin
            sensors_input = vecs[i].sensors;
            save(vecs[i].setup, vecs[i].save_h, vecs[i].save_l);
            tick(vecs[i].wait_cyc - 1);
            chk_all($sformatf("v%0d", i), vecs[i].level, vecs[i].valid,
                    vecs[i].thr_h, vecs[i].thr_l, vecs[i].led1, vecs[i].led2);
        end

        // save_reject timing and threshold boundaries (level 4, thr 7/1)
        save(8'h33, 1'b1, 1'b0);
        chk("rej illegal pulse", 8'(save_reject), 8'h1);
        tick(1);
        chk("rej illegal clear", 8'(save_reject), 8'h0);
        save(8'h3F, 1'b1, 1'b0);
        chk("saveH 6 thr_high", 8'(thr_high), 8'd6);
        chk("saveH 6 no reject", 8'(save_reject), 8'h0);
        save(8'h0F, 1'b1, 1'b1);
        chk("both reject", 8'(save_reject), 8'h1);
        chk("both thr_high", 8'(thr_high), 8'd6);
        chk("both thr_low", 8'(thr_low), 8'd1);
        save(8'h3F, 1'b0, 1'b1);
        chk("saveL eq high reject", 8'(save_reject), 8'h1);
        chk("saveL eq high thr_low", 8'(thr_low), 8'd1);
        save(8'h03, 1'b1, 1'b0);
        chk("saveH low+1 thr_high", 8'(thr_high), 8'd2);
        chk("saveH low+1 no reject", 8'(save_reject), 8'h0);
        save(8'h7F, 1'b1, 1'b0);
        chk("restore thr_high", 8'(thr_high), 8'd7);
        tick(3);

        // Input toggling faster than the filter never updates level
        for (int s = 0; s < 6; s++) begin
            sensors_input = (s % 2 == 0) ? 8'h1F : 8'h0F;
            tick(10);
            chk($sformatf("toggle %0d level", s), 8'(level), 8'd4);
        end

        // Reset in mid-alarm and mid-debounce
        save(8'h3F, 1'b1, 1'b0);
        sensors_input = 8'hFF;
        tick(20);
        chk_all("pre-reset high", 4'd8, 1'b1, 4'd6, 4'd1, 1'b1, 1'b0);
        sensors_input = 8'h0F;
        tick(5);
        reset_n = 1'b0;
        tick(1);
        chk_all("mid reset", 4'd0, 1'b0, 4'd7, 4'd1, 1'b0, 1'b0);
        chk("mid reset save_reject", 8'(save_reject), 8'h0);
        reset_n = 1'b1;
        tick(1);
        chk_all("rerun fault", 4'd0, 1'b0, 4'd7, 4'd1, 1'b1, 1'b1);
        tick(16);
        chk("rerun c17 level", 8'(level), 8'd0);
        tick(1);
        chk("rerun c18 level", 8'(level), 8'd4);
        chk("rerun c18 valid", 8'(level_valid), 8'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
